// File: rtl/virtio_cfg_ext_router.sv
// virtio_cfg_ext_router: routes XDMA cfg_ext accesses to register windows via req/ack
module virtio_cfg_ext_router #(
  parameter int NUM_WIN = 2,
  parameter logic [NUM_WIN*10-1:0] WIN_BASE = {10'h140, 10'h120},
  parameter logic [NUM_WIN*10-1:0] WIN_LAST = {10'h17F, 10'h13F},
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cfg_ext_function_number,
  input  logic                   cfg_ext_read_received,
  input  logic                   cfg_ext_write_received,
  input  logic [9:0]             cfg_ext_register_number,
  input  logic [3:0]             cfg_ext_write_byte_enable,
  input  logic [31:0]            cfg_ext_write_data,
  output logic [31:0]            cfg_ext_read_data,
  output logic                   cfg_ext_read_data_valid,
  output logic [NUM_WIN-1:0]     win_req,
  output logic                   win_we,
  output logic [9:0]             win_addr,
  output logic [7:0]             win_func,
  output logic [3:0]             win_be,
  output logic [31:0]            win_wdata,
  input  logic [NUM_WIN-1:0]     win_ack,
  input  logic [NUM_WIN*32-1:0]  win_rdata,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_drop
);
  localparam int IW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  typedef enum logic [1:0] {IDLE, REQ, MISS, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [9:0]  rn;
    logic [7:0]  fn;
    logic [3:0]  be;
    logic [31:0] wd;
  } ent_t;
  state_t             state_q;
  ent_t               pend_q, new_e, src;
  logic               pend_full_q, strobe, drop, hit, ack;
  logic               we_q, valid_q, to_q, drop_q;
  logic [7:0]         fn_q, cnt_q;
  logic [3:0]         be_q;
  logic [31:0]        wd_q, rdata_q, sel_rdata;
  logic [IW-1:0]      idx, sel_q;
  logic [9:0]         base, addr_q;
  logic [NUM_WIN-1:0] req_q;
  assign strobe = cfg_ext_read_received | cfg_ext_write_received;
  // a simultaneous read/write strobe is taken as a read
  assign new_e = {~cfg_ext_read_received, cfg_ext_register_number, cfg_ext_function_number,
                  cfg_ext_write_byte_enable, cfg_ext_write_data};
  assign drop = (cfg_ext_read_received & cfg_ext_write_received) |
                (strobe & (state_q != IDLE) & pend_full_q);
  assign ack = win_ack[sel_q];
  assign sel_rdata = win_rdata[32*sel_q +: 32];
  // lowest-index window wins on overlapping ranges
  always_comb begin
    src = pend_full_q ? pend_q : new_e;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--)
      if (src.rn >= WIN_BASE[i*10 +: 10] && src.rn <= WIN_LAST[i*10 +: 10]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    base = WIN_BASE[10*idx +: 10];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      we_q        <= 1'b0;
      fn_q        <= '0;
      be_q        <= '0;
      wd_q        <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      to_q        <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q  <= drop;
      to_q    <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      if (state_q == IDLE) pend_full_q <= pend_full_q & strobe;
      else if (strobe) pend_full_q <= 1'b1;
      if (strobe && !(state_q != IDLE && pend_full_q)) pend_q <= new_e;
      case (state_q)
        IDLE: if (pend_full_q || strobe) begin
          we_q    <= src.we;
          fn_q    <= src.fn;
          be_q    <= src.be;
          wd_q    <= src.wd;
          sel_q   <= idx;
          addr_q  <= src.rn - base;
          cnt_q   <= '0;
          req_q   <= hit ? NUM_WIN'(1) << idx : '0;
          state_q <= hit ? REQ : MISS;
        end
        REQ: if (ack) begin
          req_q   <= '0;
          rdata_q <= we_q ? '0 : sel_rdata;
          valid_q <= ~we_q;
          state_q <= we_q ? IDLE : RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          req_q   <= '0;
          to_q    <= 1'b1;
          rdata_q <= {32{~we_q}};
          valid_q <= ~we_q;
          state_q <= we_q ? IDLE : RESP;
        end else cnt_q <= cnt_q + 8'd1;
        MISS: begin
          valid_q <= ~we_q;
          state_q <= we_q ? IDLE : RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cfg_ext_read_data       = rdata_q;
  assign cfg_ext_read_data_valid = valid_q;
  assign win_req                 = req_q;
  assign win_we                  = we_q;
  assign win_addr                = addr_q;
  assign win_func                = fn_q;
  assign win_be                  = be_q;
  assign win_wdata               = wd_q;
  assign busy                    = (state_q != IDLE) | pend_full_q;
  assign err_timeout             = to_q;
  assign err_drop                = drop_q;
endmodule

// File: tb/tb_virtio_cfg_ext_router.sv
// tb_virtio_cfg_ext_router: vector table plus corner sequences, read data via scoreboard
module tb_virtio_cfg_ext_router;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  func;
  logic        rd, wr;
  logic [9:0]  rn;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] cfg_ext_read_data;
  logic        cfg_ext_read_data_valid;
  logic [1:0]  win_req, win_ack;
  logic        win_we, busy, err_timeout, err_drop;
  logic [9:0]  win_addr;
  logic [7:0]  win_func;
  logic [3:0]  win_be;
  logic [31:0] win_wdata;
  logic [63:0] win_rdata = {32'h1234_5678, 32'h4A01_000B};
  int dly[2];
  bit en[2];
  int rc[2];
  int compared = 0;
  int failed = 0;
  int to_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rd, wr;
    logic [9:0]  rn;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  req;
    logic [9:0]  addr;
    logic [31:0] rdat;
  } vec_t;
  vec_t tv[9];

  virtio_cfg_ext_router dut (
    .clk(clk), .rst(rst),
    .cfg_ext_function_number(func),
    .cfg_ext_read_received(rd),
    .cfg_ext_write_received(wr),
    .cfg_ext_register_number(rn),
    .cfg_ext_write_byte_enable(be),
    .cfg_ext_write_data(wd),
    .cfg_ext_read_data(cfg_ext_read_data),
    .cfg_ext_read_data_valid(cfg_ext_read_data_valid),
    .win_req(win_req), .win_we(win_we), .win_addr(win_addr),
    .win_func(win_func), .win_be(win_be), .win_wdata(win_wdata),
    .win_ack(win_ack), .win_rdata(win_rdata),
    .busy(busy), .err_timeout(err_timeout), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // responder: acks once req has been high for dly[w] extra cycles
  always @(posedge clk)
    for (int w = 0; w < 2; w++) rc[w] <= win_req[w] ? rc[w] + 1 : 0;
  always_comb begin
    win_ack = '0;
    for (int w = 0; w < 2; w++) win_ack[w] = win_req[w] & en[w] & (rc[w] >= dly[w]);
  end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    to_cnt += int'(err_timeout);
    compared++;
    if (cfg_ext_read_data_valid) begin
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_valid: got data %h with no read outstanding", cfg_ext_read_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cfg_ext_read_data !== e) begin
          failed++;
          $display("FAIL read_data: got %h expected %h", cfg_ext_read_data, e);
        end
      end
    end else if (cfg_ext_read_data !== 32'h0) begin
      failed++;
      $display("FAIL idle_data: got %h expected 00000000", cfg_ext_read_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic r, input logic w, input logic [9:0] n,
                       input logic [3:0] b, input logic [31:0] d);
    rd = r; wr = w; rn = n; be = b; wd = d; func = 8'h5A;
    step();
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n2, n3, vcyc, tsave;
    tv[0] = '{1'b1, 1'b0, 10'h120, 4'h0, 32'h0,         2'b01, 10'h000, 32'h4A01_000B};
    tv[1] = '{1'b1, 1'b0, 10'h13F, 4'h0, 32'h0,         2'b01, 10'h01F, 32'h4A01_000B};
    tv[2] = '{1'b1, 1'b0, 10'h140, 4'h0, 32'h0,         2'b10, 10'h000, 32'h1234_5678};
    tv[3] = '{1'b1, 1'b0, 10'h17F, 4'h0, 32'h0,         2'b10, 10'h03F, 32'h1234_5678};
    tv[4] = '{1'b1, 1'b0, 10'h11F, 4'h0, 32'h0,         2'b00, 10'h000, 32'h0};
    tv[5] = '{1'b1, 1'b0, 10'h180, 4'h0, 32'h0,         2'b00, 10'h000, 32'h0};
    tv[6] = '{1'b0, 1'b1, 10'h150, 4'hC, 32'hCAFE_0001, 2'b10, 10'h010, 32'h0};
    tv[7] = '{1'b0, 1'b1, 10'h0A0, 4'hF, 32'h1111_2222, 2'b00, 10'h000, 32'h0};
    tv[8] = '{1'b1, 1'b0, 10'h0A0, 4'h0, 32'h0,         2'b00, 10'h000, 32'h0};
    dly[0] = 0; dly[1] = 0; en[0] = 1; en[1] = 1;
    rd = 0; wr = 0; rn = 0; be = 0; wd = 0; func = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(win_req), 0);
    chk("rst_valid", 32'(cfg_ext_read_data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", 32'({err_timeout, err_drop}), 0);
    chk("rst_addr", 32'(win_addr), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      if (tv[i].rd) exp_q.push_back(tv[i].rdat);
      issue(tv[i].rd, tv[i].wr, tv[i].rn, tv[i].be, tv[i].wd);
      chk($sformatf("t%0d_req", i), 32'(win_req), 32'(tv[i].req));
      chk($sformatf("t%0d_we", i), 32'(win_we), 32'(~tv[i].rd & tv[i].wr));
      if (tv[i].req != 2'b00) chk($sformatf("t%0d_addr", i), 32'(win_addr), 32'(tv[i].addr));
      if (tv[i].wr && tv[i].req != 2'b00) begin
        chk($sformatf("t%0d_be", i), 32'(win_be), 32'(tv[i].be));
        chk($sformatf("t%0d_wdata", i), win_wdata, tv[i].wd);
      end
      step();
      chk($sformatf("t%0d_valid_c2", i), 32'(cfg_ext_read_data_valid), 32'(tv[i].rd));
      step();
      chk($sformatf("t%0d_valid_c3", i), 32'(cfg_ext_read_data_valid), 0);
      chk($sformatf("t%0d_busy_c3", i), 32'(busy), 0);
      step();
    end

    // write to window 1 acked on the third req cycle
    dly[1] = 2;
    issue(1'b0, 1'b1, 10'h145, 4'b0011, 32'hDEAD_BEEF);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("wr_req_c%0d", c), 32'(win_req), 32'h2);
      chk($sformatf("wr_addr_c%0d", c), 32'(win_addr), 32'h5);
      chk($sformatf("wr_we_c%0d", c), 32'(win_we), 32'h1);
      step();
    end
    chk("wr_be", 32'(win_be), 32'h3);
    chk("wr_data", win_wdata, 32'hDEAD_BEEF);
    chk("wr_req_done", 32'(win_req), 0);
    chk("wr_busy_done", 32'(busy), 0);
    dly[1] = 0;
    step();

    // timeout on window 0
    en[0] = 0;
    tsave = to_cnt;
    exp_q.push_back(32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 10'h130, 4'h0, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("to_req_c%0d", c), 32'(win_req), 32'h1);
      if (c == 16) chk("to_err_early", 32'(err_timeout), 0);
      step();
    end
    chk("to_req_c17", 32'(win_req), 0);
    chk("to_err_c17", 32'(err_timeout), 1);
    chk("to_valid_c17", 32'(cfg_ext_read_data_valid), 1);
    chk("to_data_c17", cfg_ext_read_data, 32'hFFFF_FFFF);
    step();
    chk("to_err_c18", 32'(err_timeout), 0);
    chk("to_valid_c18", 32'(cfg_ext_read_data_valid), 0);
    chk("to_busy_c18", 32'(busy), 0);
    chk("to_pulses", 32'(to_cnt - tsave), 1);
    en[0] = 1;
    step();

    // back-to-back: stalled read, buffered write, dropped write
    dly[0] = 4;
    exp_q.push_back(32'h4A01_000B);
    issue(1'b1, 1'b0, 10'h121, 4'h0, 32'h0);
    step();
    chk("b2b_busy_c2", 32'(busy), 1);
    issue(1'b0, 1'b1, 10'h122, 4'hF, 32'hAAAA_0122);
    chk("b2b_drop_c3", 32'(err_drop), 0);
    issue(1'b0, 1'b1, 10'h123, 4'hF, 32'hAAAA_0123);
    chk("b2b_drop_c4", 32'(err_drop), 1);
    n2 = 0; n3 = 0; vcyc = -1;
    for (int c = 4; c < 44 && busy; c++) begin
      if (cfg_ext_read_data_valid) vcyc = c;
      if (win_req != 2'b00 && win_we && win_addr == 10'h2) n2++;
      if (win_req != 2'b00 && win_we && win_addr == 10'h3) n3++;
      step();
    end
    chk("b2b_idle", 32'(busy), 0);
    chk("b2b_valid_cycle", 32'(vcyc), 6);
    chk("b2b_wr122_cycles", 32'(n2), 5);
    chk("b2b_wr123_cycles", 32'(n3), 0);
    dly[0] = 0;
    step();

    // simultaneous read and write strobes
    exp_q.push_back(32'h1234_5678);
    issue(1'b1, 1'b1, 10'h140, 4'hF, 32'h5555_5555);
    chk("rw_req", 32'(win_req), 32'h2);
    chk("rw_we", 32'(win_we), 0);
    chk("rw_drop", 32'(err_drop), 1);
    step();
    chk("rw_valid", 32'(cfg_ext_read_data_valid), 1);
    chk("rw_drop_c2", 32'(err_drop), 0);
    step();
    step();

    // reset while a read is waiting in REQ
    en[0] = 0;
    tsave = to_cnt;
    issue(1'b1, 1'b0, 10'h125, 4'h0, 32'h0);
    step();
    chk("mr_req_before", 32'(win_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("mr_req", 32'(win_req), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_valid", 32'(cfg_ext_read_data_valid), 0);
    chk("mr_errs", 32'({err_timeout, err_drop}), 0);
    chk("mr_fields", 32'({win_we, win_addr, win_func, win_be}), 0);
    chk("mr_wdata", win_wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (25) step();
    chk("mr_busy_after", 32'(busy), 0);
    chk("mr_no_timeout", 32'(to_cnt - tsave), 0);
    en[0] = 1;
    step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
